// File: rtl/t03_ssdisp_pkg.sv
// Shared types for the multiplexed seven-segment digit scanner.
// Holds the scan FSM encoding and the leading-zero blanking rule.
package t03_ssdisp_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Digit k is a leading zero when it and every digit above it are zero.
  function automatic logic lz_blank(
    input logic [15:0] v,
    input logic [1:0]  k
  );
    return (k != 2'd0) && ((v >> {k, 2'b00}) == 16'h0000);
  endfunction

endpackage

// File: rtl/t03_dwell_counter.sv
// Terminal-count dwell timer: pulses done on the tc-th cycle and
// restarts from zero, so both GUARD and DRIVE slots share it.
module t03_dwell_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] tc,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    done  = (cnt_q == tc);
    cnt_d = done ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/t03_ssdigit_scan.sv
// Four-digit hex scanner with guard gaps, frame-aligned value commit
// and optional leading-zero blanking; all outputs come from flops.
module t03_ssdigit_scan
  import t03_ssdisp_pkg::*;
#(
  parameter int DIV_CYCLES   = 1000,
  parameter int GUARD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        blank_lz,
  output logic [3:0]  digit_nibble,
  output logic        digit_en,
  output logic [3:0]  digit_sel,
  output logic        frame_done
);

  localparam int MAXC = (DIV_CYCLES > GUARD_CYCLES) ? DIV_CYCLES : GUARD_CYCLES;
  localparam int CW   = $clog2(MAXC);

  scan_state_t state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] active_q, active_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic        ready_q, ready_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  nib_q, nib_d;
  logic        en_q, en_d;
  logic        fd_q, fd_d;
  logic        frame_end;
  logic        cnt_done;
  logic [CW-1:0] tc;

  assign tc = (state_q == GUARD) ? CW'(GUARD_CYCLES - 1)
                                 : CW'(DIV_CYCLES - 1);

  t03_dwell_counter #(
    .W (CW)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .tc   (tc),
    .done (cnt_done)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_end = 1'b0;
    if (cnt_done) begin
      if (state_q == GUARD) begin
        state_d = DRIVE;
      end else begin
        state_d   = GUARD;
        idx_d     = idx_q + 2'd1;
        frame_end = (idx_q == 2'(NUM_DIGITS - 1));
      end
    end
  end

  // Commit and accept are exclusive: ready_q is low whenever pend_v_q is set.
  always_comb begin
    active_d = active_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (frame_end && pend_v_q) begin
      active_d = pend_q;
      pend_v_d = 1'b0;
    end
    if (load_valid && ready_q) begin
      pend_d   = load_data;
      pend_v_d = 1'b1;
    end
    ready_d = !pend_v_d;
  end

  always_comb begin
    sel_d = 4'b0000;
    nib_d = 4'h0;
    en_d  = 1'b0;
    fd_d  = frame_end;
    if (state_d == DRIVE) begin
      sel_d = 4'b0001 << idx_d;
      nib_d = active_d[{idx_d, 2'b00} +: 4];
      en_d  = !(blank_lz && lz_blank(active_d, idx_d));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GUARD;
      idx_q    <= 2'd0;
      active_q <= 16'h0000;
      pend_q   <= 16'h0000;
      pend_v_q <= 1'b0;
      ready_q  <= 1'b1;
      sel_q    <= 4'b0000;
      nib_q    <= 4'h0;
      en_q     <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ready_q  <= ready_d;
      sel_q    <= sel_d;
      nib_q    <= nib_d;
      en_q     <= en_d;
      fd_q     <= fd_d;
    end
  end

  assign load_ready   = ready_q;
  assign digit_sel    = sel_q;
  assign digit_nibble = nib_q;
  assign digit_en     = en_q;
  assign frame_done   = fd_q;

endmodule

// File: tb/tb_t03_ssdigit_scan.sv
// Directed bench for the digit scanner at DIV_CYCLES=4, GUARD_CYCLES=1
// (5-cycle slots, 20-cycle frames); outputs sampled on the falling edge.
module tb_t03_ssdigit_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        blank_lz;
  logic [3:0]  digit_nibble;
  logic        digit_en;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int          vecs = 0;
  int          miscompares = 0;
  int          k;
  logic [15:0] exp_active;

  always #5 clk = ~clk;

  t03_ssdigit_scan #(
    .DIV_CYCLES   (4),
    .GUARD_CYCLES (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .blank_lz     (blank_lz),
    .digit_nibble (digit_nibble),
    .digit_en     (digit_en),
    .digit_sel    (digit_sel),
    .frame_done   (frame_done)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s k=%0d got %h expected %h", tag, k, got, exp);
    end
  endtask

  // Cycle k after reset: slot p=k%5 (0 is guard), digit (k/5)%4.
  task automatic check_outputs();
    int p;
    int d;
    logic [3:0] e_sel;
    logic [3:0] e_nib;
    logic       e_en;
    p = k % 5;
    d = (k / 5) % 4;
    e_sel = 4'b0000;
    e_nib = 4'h0;
    e_en  = 1'b0;
    if (p != 0) begin
      e_sel = 4'b0001 << d;
      e_nib = exp_active[4*d +: 4];
      e_en  = !(blank_lz && d != 0 && (exp_active >> (4*d)) == 16'h0);
    end
    chk("sel", {12'h0, digit_sel}, {12'h0, e_sel});
    chk("nib", {12'h0, digit_nibble}, {12'h0, e_nib});
    chk("en", {15'h0, digit_en}, {15'h0, e_en});
    chk("fdone", {15'h0, frame_done},
        {15'h0, (k % 20 == 0) && (k != 0)});
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0;
    blank_lz   = 1'b0;
    k          = 0;
    exp_active = 16'h0;
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    chk("rdy_rst", {15'h0, load_ready}, 16'h1);
    rst = 1'b0;

    // free-running scan of zeros across two frames
    run_to(40);

    // mid-frame load, commit at frame end only
    run_to(43);
    load_valid = 1'b1;
    load_data  = 16'hA5C3;
    step();
    load_valid = 1'b0;
    chk("rdy_low", {15'h0, load_ready}, 16'h0);
    run_to(59);
    chk("rdy_hold", {15'h0, load_ready}, 16'h0);
    exp_active = 16'hA5C3;
    step();
    chk("rdy_commit", {15'h0, load_ready}, 16'h1);

    // second value held while pending is full
    run_to(83);
    load_valid = 1'b1;
    load_data  = 16'h1111;
    step();
    load_data  = 16'h2222;
    chk("rdy_p1", {15'h0, load_ready}, 16'h0);
    run_to(99);
    chk("rdy_p2", {15'h0, load_ready}, 16'h0);
    exp_active = 16'h1111;
    step();
    chk("rdy_p3", {15'h0, load_ready}, 16'h1);
    step();
    load_valid = 1'b0;
    chk("rdy_p4", {15'h0, load_ready}, 16'h0);
    run_to(119);
    exp_active = 16'h2222;
    step();
    chk("rdy_p5", {15'h0, load_ready}, 16'h1);

    // leading-zero blanking
    run_to(122);
    load_valid = 1'b1;
    load_data  = 16'h0070;
    step();
    load_valid = 1'b0;
    run_to(125);
    blank_lz = 1'b1;
    run_to(139);
    exp_active = 16'h0070;
    step();
    run_to(145);
    load_valid = 1'b1;
    load_data  = 16'h0000;
    step();
    load_valid = 1'b0;
    run_to(159);
    exp_active = 16'h0000;
    step();
    run_to(172);
    blank_lz = 1'b0;

    // reset during digit 2 with a value pending
    run_to(182);
    load_valid = 1'b1;
    load_data  = 16'h1234;
    step();
    load_valid = 1'b0;
    chk("rdy_pre_rst", {15'h0, load_ready}, 16'h0);
    run_to(192);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 0;
    exp_active = 16'h0000;
    check_outputs();
    chk("rdy_after_rst", {15'h0, load_ready}, 16'h1);
    rst = 1'b0;
    run_to(45);
    chk("rdy_end", {15'h0, load_ready}, 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
